// File: rtl/dpe_pp_acc.sv
// rtl/dpe_pp_acc.sv - ping-pong weight dot-product engine with multi-beat accumulation
module dpe_pp_acc #(
    parameter int EW    = 8,
    parameter int LANES = 40,
    parameter int NDOT  = 3,
    parameter int ACCW  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ena,
    input  logic [EW*LANES-1:0]     din_a,
    input  logic                    valid_a,
    input  logic                    acc_first,
    input  logic                    acc_last,
    input  logic                    cmp_bank,
    input  logic [EW*LANES-1:0]     wgt_din,
    input  logic                    wgt_valid,
    input  logic                    wgt_bank,
    input  logic [$clog2(NDOT)-1:0] wgt_idx,
    output logic [NDOT*ACCW-1:0]    dout,
    output logic                    val_res,
    output logic                    sat,
    output logic                    seq_err,
    output logic                    wgt_err
);
    localparam int TREE_LV = $clog2(LANES);
    localparam int SUMW    = 2*EW + TREE_LV;
    localparam int AW      = ((SUMW > ACCW) ? SUMW : ACCW) + 2;
    localparam int FIN     = TREE_LV + 1;
    localparam logic signed [AW-1:0] ACC_MAX = {{(AW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};

    function automatic int lvl_cnt(input int l);
        return (LANES + (1 << l) - 1) >> l;
    endfunction

    function automatic logic signed [2*EW-1:0] mul(input logic signed [EW-1:0] a,
                                                   input logic signed [EW-1:0] b);
        return a * b;
    endfunction

    logic signed [EW-1:0]   bank [2][NDOT][LANES];
    logic signed [EW-1:0]   a_q  [LANES];
    logic signed [EW-1:0]   w_q  [NDOT][LANES];
    logic [FIN:0]           pv, pf, pl;
    logic signed [SUMW-1:0] sum    [NDOT];
    logic signed [AW-1:0]   base   [NDOT];
    logic signed [AW-1:0]   tot    [NDOT];
    logic signed [ACCW-1:0] acc_nx [NDOT];
    logic signed [ACCW-1:0] acc    [NDOT];
    logic [NDOT-1:0]        clip;
    logic                   open, eff_first, proto_err, val_q;

    // Weight storage has no reset and keeps loading while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (wgt_valid && (32'(wgt_idx) < NDOT))
            for (int j = 0; j < LANES; j++)
                bank[wgt_bank][wgt_idx][j] <= wgt_din[j*EW +: EW];
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            for (int j = 0; j < LANES; j++) begin
                a_q[j] <= din_a[j*EW +: EW];
                for (int d = 0; d < NDOT; d++)
                    w_q[d][j] <= bank[cmp_bank][d][j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv <= '0;
            pf <= '0;
            pl <= '0;
        end else if (ena) begin
            pv <= {pv[FIN-1:0], valid_a};
            pf <= {pf[FIN-1:0], acc_first};
            pl <= {pl[FIN-1:0], acc_last};
        end
    end

    // Level 0 holds the products; each later level halves, carrying an odd last node through
    for (genvar l = 0; l <= TREE_LV; l++) begin : g_lvl
        localparam int N = lvl_cnt(l);
        for (genvar j = 0; j < N; j++) begin : g_node
            logic signed [SUMW-1:0] v [NDOT];
            if (l == 0) begin : g_mul
                always_ff @(posedge clk)
                    if (ena)
                        for (int d = 0; d < NDOT; d++)
                            v[d] <= SUMW'(mul(a_q[j], w_q[d][j]));
            end else if (2*j+1 < lvl_cnt(l-1)) begin : g_add
                always_ff @(posedge clk)
                    if (ena)
                        for (int d = 0; d < NDOT; d++)
                            v[d] <= g_lvl[l-1].g_node[2*j].v[d] + g_lvl[l-1].g_node[2*j+1].v[d];
            end else begin : g_pass
                always_ff @(posedge clk)
                    if (ena)
                        for (int d = 0; d < NDOT; d++)
                            v[d] <= g_lvl[l-1].g_node[2*j].v[d];
            end
        end
    end

    for (genvar d = 0; d < NDOT; d++) begin : g_root
        assign sum[d] = g_lvl[TREE_LV].g_node[0].v[d];
    end

    // A continuation with nothing open restarts; a first while open drops the partial
    always_comb begin
        eff_first = pf[FIN] | ~open;
        proto_err = pf[FIN] ? open : ~open;
        clip      = '0;
        for (int d = 0; d < NDOT; d++) begin
            base[d] = AW'(acc[d]);
            if (eff_first)
                base[d] = '0;
            tot[d]    = AW'(sum[d]) + base[d];
            acc_nx[d] = tot[d][ACCW-1:0];
            if (tot[d] > ACC_MAX) begin
                acc_nx[d] = ACC_MAX[ACCW-1:0];
                clip[d]   = 1'b1;
            end else if (tot[d] < ACC_MIN) begin
                acc_nx[d] = ACC_MIN[ACCW-1:0];
                clip[d]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < NDOT; d++)
                acc[d] <= '0;
            dout    <= '0;
            val_q   <= 1'b0;
            open    <= 1'b0;
            sat     <= 1'b0;
            seq_err <= 1'b0;
        end else if (ena) begin
            val_q <= pv[FIN] & pl[FIN];
            if (pv[FIN]) begin
                for (int d = 0; d < NDOT; d++)
                    acc[d] <= acc_nx[d];
                open <= ~pl[FIN];
                if (proto_err)
                    seq_err <= 1'b1;
                if (pl[FIN]) begin
                    for (int d = 0; d < NDOT; d++)
                        dout[d*ACCW +: ACCW] <= acc_nx[d];
                    if (|clip)
                        sat <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wgt_err <= 1'b0;
        else if (wgt_valid && !(32'(wgt_idx) < NDOT))
            wgt_err <= 1'b1;
    end

    assign val_res = val_q & ena;

endmodule

// File: tb/tb_dpe_pp_acc.sv
// tb/tb_dpe_pp_acc.sv - randomized and directed bench for dpe_pp_acc against an arithmetic model
module tb_dpe_pp_acc;
    localparam int EW    = 8;
    localparam int LANES = 40;
    localparam int NDOT  = 3;
    localparam int ACCW  = 32;
    localparam int LAT   = 3 + $clog2(LANES);
    localparam longint AMAX = (longint'(1) << (ACCW-1)) - 1;
    localparam longint AMIN = -(longint'(1) << (ACCW-1));

    logic                    clk = 1'b0;
    logic                    reset, ena, valid_a, acc_first, acc_last, cmp_bank;
    logic                    wgt_valid, wgt_bank;
    logic [EW*LANES-1:0]     din_a, wgt_din;
    logic [$clog2(NDOT)-1:0] wgt_idx;
    logic [NDOT*ACCW-1:0]    dout;
    logic                    val_res, sat, seq_err, wgt_err;

    dpe_pp_acc dut (
        .clk(clk), .reset(reset), .ena(ena), .din_a(din_a), .valid_a(valid_a),
        .acc_first(acc_first), .acc_last(acc_last), .cmp_bank(cmp_bank),
        .wgt_din(wgt_din), .wgt_valid(wgt_valid), .wgt_bank(wgt_bank), .wgt_idx(wgt_idx),
        .dout(dout), .val_res(val_res), .sat(sat), .seq_err(seq_err), .wgt_err(wgt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NDOT*ACCW-1:0] d;
        logic                 s;
        logic                 q;
        int                   tag;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     wb [2][NDOT][LANES];
    longint m_acc [NDOT];
    bit     m_open, m_sat, m_seq, m_wgt;
    int     ecnt = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    int     n;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] dot(input int d);
        return 64'($signed(dout[d*ACCW +: ACCW]));
    endfunction

    function automatic logic [EW*LANES-1:0] vconst(input int c);
        logic [EW*LANES-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*EW +: EW] = c[EW-1:0];
        return r;
    endfunction

    function automatic logic [EW*LANES-1:0] vidx();
        logic [EW*LANES-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*EW +: EW] = EW'(j);
        return r;
    endfunction

    function automatic logic [EW*LANES-1:0] vrand();
        logic [EW*LANES-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*EW +: EW] = EW'($urandom);
        return r;
    endfunction

    // Beats read the weights as they stand before this edge's write lands
    function automatic void model_edge();
        longint s, t;
        bit     ef, clipped;
        exp_t   e;
        if (ena && valid_a) begin
            ef = acc_first || !m_open;
            if (acc_first == m_open) m_seq = 1'b1;
            clipped = 1'b0;
            for (int d = 0; d < NDOT; d++) begin
                s = 0;
                for (int j = 0; j < LANES; j++)
                    s += longint'($signed(din_a[j*EW +: EW])) * wb[cmp_bank][d][j];
                t = ef ? s : m_acc[d] + s;
                if (t > AMAX) begin t = AMAX; clipped = 1'b1; end
                if (t < AMIN) begin t = AMIN; clipped = 1'b1; end
                m_acc[d] = t;
                e.d[d*ACCW +: ACCW] = t[ACCW-1:0];
            end
            if (acc_last) begin
                if (clipped) m_sat = 1'b1;
                e.s   = m_sat;
                e.q   = m_seq;
                e.tag = ecnt;
                exp_q.push_back(e);
            end
            m_open = !acc_last;
        end
        if (wgt_valid) begin
            if (int'(wgt_idx) < NDOT)
                for (int j = 0; j < LANES; j++)
                    wb[wgt_bank][wgt_idx][j] = int'($signed(wgt_din[j*EW +: EW]));
            else
                m_wgt = 1'b1;
        end
    endfunction

    task automatic tick();
        if (!reset) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input bit b, input int r, input logic [EW*LANES-1:0] v);
        wgt_valid = 1'b1; wgt_bank = b; wgt_idx = r[$clog2(NDOT)-1:0]; wgt_din = v;
        tick();
        wgt_valid = 1'b0;
    endtask

    task automatic beat(input logic [EW*LANES-1:0] v, input bit f, input bit l, input bit b);
        valid_a = 1'b1; din_a = v; acc_first = f; acc_last = l; cmp_bank = b;
        tick();
        valid_a = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
    endtask

    // Edges from the accepting edge up to and including the one that shows val_res
    task automatic wait_res(output int edges);
        edges = 1;
        while (!val_res && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    always @(posedge clk) if (!reset && ena) ecnt++;

    always @(negedge clk) begin
        if (!reset) begin
            if (!ena) begin
                check("val_res_masked", val_res, 0);
            end else if (val_res) begin
                check("val_res_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    for (int d = 0; d < NDOT; d++)
                        check("dout_dot", dot(d), 64'($signed(mon_e.d[d*ACCW +: ACCW])));
                    check("sat_flag", sat, mon_e.s);
                    check("seq_err_flag", seq_err, mon_e.q);
                    check("latency_ena", ecnt - mon_e.tag, LAT);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ena = 1'b1; valid_a = 1'b0; acc_first = 1'b0; acc_last = 1'b0; cmp_bank = 1'b0;
        wgt_valid = 1'b0; wgt_bank = 1'b0; wgt_idx = '0; din_a = '0; wgt_din = '0;
        m_open = 0; m_sat = 0; m_seq = 0; m_wgt = 0;
        for (int d = 0; d < NDOT; d++) m_acc[d] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_dout", dout, 0);
        check("rst_val_res", val_res, 0);
        check("rst_sat", sat, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_wgt_err", wgt_err, 0);
        reset = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NDOT; r++) write_row(b[0], r, vrand());

        // basic dot products
        write_row(0, 0, vconst(1));
        write_row(0, 1, vconst(-1));
        write_row(0, 2, vidx());
        beat(vconst(2), 1, 1, 0);
        wait_res(n);
        check("t1_latency", n, 9);
        check("t1_dot0", dot(0), 80);
        check("t1_dot1", dot(1), -80);
        check("t1_dot2", dot(2), 1560);
        tick();
        check("t1_one_cycle", val_res, 0);
        drain();

        // three-beat accumulation
        for (int r = 0; r < NDOT; r++) write_row(1, r, vconst(1));
        beat(vconst(1), 1, 0, 1);
        beat(vconst(1), 0, 0, 1);
        beat(vconst(1), 0, 1, 1);
        wait_res(n);
        check("t2_latency", n, 9);
        for (int d = 0; d < NDOT; d++) check("t2_dot", dot(d), 120);
        drain();

        // positive saturation over a long accumulation
        for (int r = 0; r < NDOT; r++) write_row(0, r, vconst(127));
        beat(vconst(127), 1, 0, 0);
        for (int i = 0; i < 3400; i++) beat(vconst(127), 0, 0, 0);
        beat(vconst(127), 0, 1, 0);
        wait_res(n);
        check("t3_latency", n, 9);
        for (int d = 0; d < NDOT; d++) check("t3_clip", dot(d), AMAX);
        check("t3_sat", sat, 1);
        drain();

        // same-cycle write to the row being read returns the old row
        write_row(0, 0, vconst(1));
        wgt_valid = 1'b1; wgt_bank = 1'b0; wgt_idx = '0; wgt_din = vconst(5);
        beat(vconst(1), 1, 1, 0);
        wgt_valid = 1'b0;
        beat(vconst(1), 1, 1, 0);
        wait_res(n);
        check("t4_old_row", dot(0), 40);
        tick();
        check("t4_new_row", dot(0), 200);
        drain();

        // compute from bank1 while rewriting bank0, then mix freely
        for (int i = 0; i < 150; i++) begin
            valid_a = $urandom_range(0, 1); din_a = vrand(); cmp_bank = 1'b1;
            acc_first = ($urandom_range(0, 3) == 0); acc_last = ($urandom_range(0, 3) == 0);
            wgt_valid = $urandom_range(0, 1); wgt_bank = 1'b0; wgt_idx = 2'($urandom_range(0, 2));
            wgt_din = vrand();
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            valid_a = $urandom_range(0, 1); din_a = vrand(); cmp_bank = $urandom_range(0, 1);
            acc_first = ($urandom_range(0, 3) == 0); acc_last = ($urandom_range(0, 3) == 0);
            wgt_valid = ($urandom_range(0, 3) == 0); wgt_bank = $urandom_range(0, 1);
            wgt_idx = 2'($urandom_range(0, 3)); wgt_din = vrand();
            tick();
        end
        ena = 1'b1; valid_a = 1'b0; wgt_valid = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
        drain();

        // four stall cycles add exactly four cycles
        beat(vrand(), 1, 1, 1);
        n = 1;
        repeat (3) begin tick(); n++; end
        ena = 1'b0;
        repeat (4) begin tick(); n++; end
        ena = 1'b1;
        while (!val_res && n < 40) begin tick(); n++; end
        check("t5_stall_latency", n, 13);
        drain();

        // reset while results are streaming out
        for (int i = 0; i < 12; i++) beat(vrand(), 1, 1, $urandom_range(0, 1));
        check("t5_pre_reset_val", val_res, 1);
        valid_a = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_reset_val_res", val_res, 0);
        check("t5_reset_dout", dout, 0);
        check("t5_reset_sat", sat, 0);
        check("t5_reset_seq_err", seq_err, 0);
        exp_q.delete();
        for (int d = 0; d < NDOT; d++) m_acc[d] = 0;
        m_open = 0; m_sat = 0; m_seq = 0; m_wgt = 0;
        tick();
        tick();
        reset = 1'b0;
        repeat (20) tick();

        // protocol error and out-of-range weight write
        for (int r = 0; r < NDOT; r++) write_row(1, r, vconst(1));
        beat(vconst(1), 1, 0, 1);
        beat(vconst(1), 0, 1, 1);
        wait_res(n);
        for (int d = 0; d < NDOT; d++) check("t6_pair", dot(d), 80);
        check("t6_seq_ok", seq_err, 0);
        drain();
        beat(vconst(3), 0, 1, 1);
        wait_res(n);
        for (int d = 0; d < NDOT; d++) check("t6_alone", dot(d), 120);
        check("t6_seq_err", seq_err, 1);
        drain();
        check("t6_wgt_err_pre", wgt_err, 0);
        write_row(1, 3, vconst(7));
        check("t6_wgt_err", wgt_err, 1);
        beat(vconst(1), 1, 1, 1);
        wait_res(n);
        for (int d = 0; d < NDOT; d++) check("t6_bank_kept", dot(d), 40);
        drain();

        check("end_wgt_err", wgt_err, m_wgt);
        check("end_sat", sat, m_sat);
        check("end_seq_err", seq_err, m_seq);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
